// File: rtl/audio_ctrl_pkg.sv
// Shared types and helpers for the I2S audio controller.
// State encoding, sample width and the saturating mixer add.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    CLK_WAIT = 2'd1,
    MUTED    = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam int AUDIO_W = 16;

  localparam logic [AUDIO_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic [AUDIO_W-1:0] SAT_MIN = 16'sh8000;

  function automatic logic [AUDIO_W-1:0] sat_add(
    input logic [AUDIO_W-1:0] a,
    input logic [AUDIO_W-1:0] b
  );
    logic [AUDIO_W:0] s;
    s = {a[AUDIO_W-1], a} + {b[AUDIO_W-1], b};
    // Overflow shows as disagreement between the two top bits.
    if (s[AUDIO_W] != s[AUDIO_W-1])
      sat_add = s[AUDIO_W] ? SAT_MIN : SAT_MAX;
    else
      sat_add = s[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/audio_src_buf.sv
// One-entry source buffer with full flag and last-value hold.
// Empty and transparent (always ready) outside RUN.
module audio_src_buf
  import audio_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               consume,
  input  logic [AUDIO_W-1:0] data,
  input  logic               valid,
  output logic               ready,
  output logic               full,
  output logic [AUDIO_W-1:0] value
);

  logic [AUDIO_W-1:0] data_q;
  logic [AUDIO_W-1:0] hold_q;
  logic               full_q;
  logic               accept;

  assign ready  = run ? (~full_q | consume) : 1'b1;
  assign accept = run & valid & ready;
  assign full   = full_q;
  assign value  = full_q ? data_q : hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (!run) begin
      data_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (accept)
        data_q <= data;
      if (consume && full_q)
        hold_q <= data_q;
      // A refill in the consuming cycle keeps the slot occupied.
      if (accept)
        full_q <= 1'b1;
      else if (consume)
        full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_audio_ctrl.sv
// I2S codec power sequencer and two-source saturating mono mixer.
// Feeds one sample per serializer frame request, silence outside RUN.
module i2s_audio_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 2000000,
  parameter int CLK_CYCLES    = 8000000,
  parameter int UNMUTE_CYCLES = 1000000,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [AUDIO_W-1:0] src0_data,
  input  logic               src0_valid,
  output logic               src0_ready,
  input  logic [AUDIO_W-1:0] src1_data,
  input  logic               src1_valid,
  output logic               src1_ready,
  input  logic               frame_req,
  output logic [AUDIO_W-1:0] sample_out,
  output logic               sample_load,
  output logic               codec_rst,
  output logic               bclk_en,
  output logic               mute_n,
  output logic               underrun,
  input  logic               underrun_clr,
  output logic [1:0]         state_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLK_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNM_LAST = CNT_W'(UNMUTE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             codec_rst_q, codec_rst_d;
  logic             bclk_en_q, bclk_en_d;
  logic             mute_n_q, mute_n_d;

  logic               run;
  logic               full0, full1;
  logic [AUDIO_W-1:0] val0, val1;

  assign run = (state_q == RUN);

  audio_src_buf u_src0 (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .consume (frame_req),
    .data    (src0_data),
    .valid   (src0_valid),
    .ready   (src0_ready),
    .full    (full0),
    .value   (val0)
  );

  audio_src_buf u_src1 (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .consume (frame_req),
    .data    (src1_data),
    .valid   (src1_valid),
    .ready   (src1_ready),
    .full    (full1),
    .value   (val1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      codec_rst_q <= 1'b1;
      bclk_en_q   <= 1'b0;
      mute_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      codec_rst_q <= codec_rst_d;
      bclk_en_q   <= bclk_en_d;
      mute_n_q    <= mute_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    codec_rst_d = codec_rst_q;
    bclk_en_d   = bclk_en_q;
    mute_n_d    = mute_n_q;
    unique case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          codec_rst_d = 1'b0;
          bclk_en_d   = 1'b1;
          cnt_d       = '0;
          state_d     = CLK_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_WAIT: begin
        bclk_en_d = 1'b1;
        if (cnt_q == CLK_LAST) begin
          cnt_d   = '0;
          state_d = MUTED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUTED: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == UNM_LAST) begin
          cnt_d    = '0;
          mute_n_d = 1'b1;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          cnt_d    = '0;
          mute_n_d = 1'b0;
          state_d  = MUTED;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Sample path: one-cycle latency from frame_req, silence outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out  <= '0;
      sample_load <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_load <= frame_req;
      if (frame_req)
        sample_out <= run ? sat_add(val0, val1) : '0;
      if (run && frame_req && (!full0 || !full1))
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

  assign codec_rst = codec_rst_q;
  assign bclk_en   = bclk_en_q;
  assign mute_n    = mute_n_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_i2s_audio_ctrl.sv
// Scoreboard bench for i2s_audio_ctrl with a queue-based source model.
// Frame requests push expected samples; a monitor pops on sample_load.
module tb_i2s_audio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] src0_data, src1_data;
  logic        src0_valid, src1_valid;
  logic        src0_ready, src1_ready;
  logic        frame_req;
  logic [15:0] sample_out;
  logic        sample_load;
  logic        codec_rst, bclk_en, mute_n, underrun;
  logic        underrun_clr;
  logic [1:0]  state_o;

  i2s_audio_ctrl #(
    .RST_CYCLES    (10),
    .CLK_CYCLES    (20),
    .UNMUTE_CYCLES (5),
    .CNT_W         (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .src0_data    (src0_data),
    .src0_valid   (src0_valid),
    .src0_ready   (src0_ready),
    .src1_data    (src1_data),
    .src1_valid   (src1_valid),
    .src1_ready   (src1_ready),
    .frame_req    (frame_req),
    .sample_out   (sample_out),
    .sample_load  (sample_load),
    .codec_rst    (codec_rst),
    .bclk_en      (bclk_en),
    .mute_n       (mute_n),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending sample per source, last used value, run flag.
  int p0[$];
  int p1[$];
  int l0, l1;
  bit m_run;
  bit m_under;

  function automatic int sat(int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sample_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_load: got sample %0d expected no load",
                 $signed(sample_out));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sample_out", int'($signed(sample_out)), e.val);
        chk("load_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(bit v0, int d0, bit v1, int d1, bit fr);
    bit r0, r1, set_u;
    int s0, s1;
    exp_t e;
    if (!m_run) begin
      p0.delete(); p1.delete(); l0 = 0; l1 = 0;
    end
    src0_valid = v0; src0_data = 16'(d0);
    src1_valid = v1; src1_data = 16'(d1);
    frame_req  = fr;
    #1;
    r0 = !m_run || fr || (p0.size() == 0);
    r1 = !m_run || fr || (p1.size() == 0);
    chk("src0_ready", int'(src0_ready), int'(r0));
    chk("src1_ready", int'(src1_ready), int'(r1));
    if (reset) begin
      p0.delete(); p1.delete(); l0 = 0; l1 = 0;
      m_under = 0;
    end else begin
      set_u = 0;
      if (fr) begin
        e.val = 0;
        if (m_run) begin
          set_u = (p0.size() == 0) || (p1.size() == 0);
          s0 = (p0.size() != 0) ? p0.pop_front() : l0;
          s1 = (p1.size() != 0) ? p1.pop_front() : l1;
          l0 = s0; l1 = s1;
          e.val = sat(s0 + s1);
        end
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      if (m_run && v0 && r0) p0.push_back(d0);
      if (m_run && v1 && r1) p1.push_back(d1);
      if (set_u) m_under = 1;
      else if (underrun_clr) m_under = 0;
    end
    @(posedge clk); #1;
    chk("underrun", int'(underrun), int'(m_under));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; enable = 0; underrun_clr = 0;
    src0_valid = 0; src1_valid = 0; src0_data = 0; src1_data = 0;
    frame_req = 0;
    m_run = 0; m_under = 0; l0 = 0; l1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_codec_rst", int'(codec_rst), 1);
    chk("rst_bclk_en", int'(bclk_en), 0);
    chk("rst_mute_n", int'(mute_n), 0);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sample_load", int'(sample_load), 0);
    chk("rst_underrun", int'(underrun), 0);

    // 1. power-up sequencing
    reset = 0; enable = 1;
    idle(9);
    chk("codec_rst_held", int'(codec_rst), 1);
    idle(1);
    chk("codec_rst_fall", int'(codec_rst), 0);
    chk("bclk_en_rise", int'(bclk_en), 1);
    chk("state_clk_wait", int'(state_o), 1);
    tick(1, 77, 1, 88, 1);
    idle(18);
    chk("state_before_muted", int'(state_o), 1);
    idle(1);
    chk("state_muted", int'(state_o), 2);
    idle(4);
    chk("mute_held", int'(mute_n), 0);
    idle(1);
    chk("mute_release", int'(mute_n), 1);
    chk("state_run", int'(state_o), 3);
    m_run = 1;

    // 2. mixing and latency
    tick(1, 1000, 1, -300, 0);
    tick(0, 0, 0, 0, 1);
    idle(1);

    // 3. saturation, plus accept-and-consume in one cycle
    tick(1, 30000, 1, 10000, 0);
    tick(0, 0, 0, 0, 1);
    tick(1, -30000, 1, -10000, 0);
    tick(0, 0, 0, 0, 1);
    tick(1, 1234, 1, -234, 0);
    tick(1, 123, 1, -23, 1);
    tick(0, 0, 0, 0, 1);

    // 4. underrun and hold
    tick(1, 0, 1, 200, 0);
    tick(0, 0, 0, 0, 1);
    tick(1, 500, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("underrun_set", int'(underrun), 1);
    underrun_clr = 1;
    idle(1);
    underrun_clr = 0;
    chk("underrun_clr", int'(underrun), 0);

    // randomized streaming in RUN
    for (int i = 0; i < 300; i++) begin
      underrun_clr = ($urandom_range(0, 7) == 0);
      tick(bit'($urandom_range(0, 1)), int'($signed(16'($urandom))),
           bit'($urandom_range(0, 1)), int'($signed(16'($urandom))),
           ($urandom_range(0, 3) == 0));
    end
    underrun_clr = 0;

    // 5. enable falls with frame_req
    tick(1, 4000, 1, 5000, 0);
    enable = 0;
    tick(0, 0, 0, 0, 1);
    m_run = 0;
    chk("mute_on_fall", int'(mute_n), 0);
    chk("state_muted2", int'(state_o), 2);
    tick(1, 9, 1, 9, 1);
    enable = 1;
    idle(3);
    enable = 0;
    idle(2);
    enable = 1;
    idle(4);
    chk("glitch_restart", int'(mute_n), 0);
    idle(1);
    chk("unmute_again", int'(mute_n), 1);
    chk("state_run2", int'(state_o), 3);
    m_run = 1;

    // 6. reset mid-RUN with full buffers
    tick(1, 11, 1, 22, 0);
    reset = 1;
    tick(0, 0, 0, 0, 0);
    reset = 0;
    m_run = 0;
    chk("rr_codec_rst", int'(codec_rst), 1);
    chk("rr_bclk_en", int'(bclk_en), 0);
    chk("rr_mute_n", int'(mute_n), 0);
    chk("rr_state", int'(state_o), 0);
    tick(1, 5, 1, 6, 1);
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_audio_ctrl.md
Name: i2s_audio_ctrl

Overview:
- Sequences the I2S codec path: codec reset hold, bit-clock enable, delayed unmute, then steady-state streaming.
- Arbitrates two 16-bit audio sources (SID voice mix, tape monitor) into one saturated mono sample per I2S frame.
- Sits between the audio producers and the I2S serializer.
- Drives the serializer's bit-clock enable and sample load, plus the codec reset and mute pins.

Parameters:
- RST_CYCLES, 2000000, clk cycles codec_rst is held high after reset.
- CLK_CYCLES, 8000000, clk cycles bclk runs before unmute is allowed.
- UNMUTE_CYCLES, 1000000, clk cycles enable must stay high before mute release.
- CNT_W, 32, width of the shared sequencing counter.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  software audio enable.
- src0_data  in  16  signed sample, SID.
- src0_valid  in  1  src0 sample offered.
- src0_ready  out  1  src0 sample accepted when valid&ready.
- src1_data  in  16  signed sample, tape.
- src1_valid  in  1  src1 sample offered.
- src1_ready  out  1  src1 handshake.
- frame_req  in  1  one-cycle pulse from the serializer at each left/right word reload.
- sample_out  out  16  signed mixed sample to the serializer.
- sample_load  out  1  one-cycle pulse; sample_out valid.
- codec_rst  out  1  codec reset, high = held.
- bclk_en  out  1  enables the serializer clock divider.
- mute_n  out  1  1 = codec unmuted.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- state_o  out  2  current FSM state.

Behaviour:
Reset values: state RST_HOLD, counter 0, codec_rst=1, bclk_en=0, mute_n=0, sample_out=0, sample_load=0, underrun=0, buffers empty, hold regs 0.

FSM (all outputs registered):
- RST_HOLD(0): counter increments. At counter==RST_CYCLES-1: codec_rst<=0, counter<=0, go CLK_WAIT.
- CLK_WAIT(1): bclk_en=1. At counter==CLK_CYCLES-1: go MUTED, counter<=0.
- MUTED(2): counter increments while enable=1 and clears to 0 when enable=0. At counter==UNMUTE_CYCLES-1 with enable=1: mute_n<=1, go RUN.
- RUN(3): if enable=0, go MUTED next edge with mute_n<=0 and counter<=0. bclk_en stays 1 and codec_rst stays 0.
- A reset at any point returns to RST_HOLD; codec_rst=1, bclk_en=0 and mute_n=0 from the following edge. A reset in flight drops any sample_load.

Source buffers (one per source):
- Each buffer is a 1-entry register plus a full flag and a hold register.
- Outside RUN: ready=1, accepted data is discarded, full=0, hold=0.
- In RUN: ready = ~full | consume, where consume = frame_req in this cycle.
- Accept and consume in the same cycle: the new data enters the buffer and full stays 1.

Frame service:
- frame_req is sampled against the current state.
- In RUN: each source uses its buffer if full, else its hold register. Each used buffer value is copied to hold and its full flag clears (unless refilled in the same cycle).
- sum = 17-bit signed src0 + src1, saturated to +32767 / -32768.
- sample_out <= sum and sample_load <= 1 on the cycle after frame_req (latency 1).
- In any state other than RUN: sample_load still pulses one cycle after frame_req, with sample_out=0 (silence).
- frame_req and an enable fall in the same cycle: the mixed sample is still issued; mute applies on the same next edge.
- Underrun: in RUN, if either buffer is empty at frame_req, underrun<=1. underrun_clr clears it; a set in the same cycle wins.
- The counter never wraps: CNT_W must hold the largest cycle parameter.

Decomposition:
- Package audio_ctrl_pkg holds:
  - the state enum: RST_HOLD=0, CLK_WAIT=1, MUTED=2, RUN=3;
  - AUDIO_W=16;
  - SAT_MAX=16'sh7FFF and SAT_MIN=16'sh8000;
  - a saturating-add function.
- One sub-module, audio_src_buf: buffer, full flag, hold register and ready logic. It is instantiated twice.
- The FSM and mixer live in the top level.

Test Plan (bench overrides RST_CYCLES=10, CLK_CYCLES=20, UNMUTE_CYCLES=5):
1. Power-up sequencing: reset, then enable=1.
   - codec_rst falls after 10 clk and bclk_en rises.
   - state reaches MUTED 20 clk later.
   - mute_n rises 5 clk after that, with state_o=3.
2. Mixing and latency: in RUN, src0=1000 and src1=-300 both accepted, then frame_req.
   - sample_out=700 and sample_load=1 exactly one cycle later.
   - Both buffers empty, ready=1.
3. Saturation: src0=30000 and src1=10000 -> sample_out=32767. src0=-30000 and src1=-10000 -> -32768.
4. Underrun and hold: in RUN, only src0=500 is supplied after a previous src1=200, then frame_req.
   - sample_out=700 and underrun=1.
   - underrun_clr pulse returns underrun to 0.
5. Mute and simultaneous events: enable falls in the same cycle as frame_req.
   - The mixed sample is issued and mute_n=0 on the next edge.
   - A subsequent frame_req gives sample_out=0.
   - enable glitched low for 2 clk in MUTED restarts the 5-cycle count.
6. Reset mid-RUN: reset is pulsed while src buffers are full.
   - Next edge: codec_rst=1, bclk_en=0, mute_n=0, underrun=0.
   - Buffers empty, and a frame_req one cycle later yields sample_out=0.
